// File: rtl/mmio_out_pkg.sv
// -----------------------------------------------------------------------------
// mmio_out_pkg
// Shared definitions for the memory-mapped output register bank:
//   - op_e         : per-slot operation encoded in address bits [3:2]
//   - SLOT_STRIDE  : byte distance between consecutive slots
//   - *_OFS        : control-slot positions relative to NUM_CH
//   - SEG_TABLE    : active-low gfedcba 7-segment patterns for 0..F
//   - seg_lookup() : nibble -> segment pattern
// -----------------------------------------------------------------------------
package mmio_out_pkg;

  typedef enum logic [1:0] {
    OP_WR  = 2'b00,
    OP_SET = 2'b01,
    OP_CLR = 2'b10,
    OP_TGL = 2'b11
  } op_e;

  localparam int SLOT_STRIDE    = 16;

  // Control slots follow directly after the last channel slot.
  localparam int HEX_CMD_OFS    = 0;
  localparam int BLINK_MASK_OFS = 1;
  localparam int BLINK_DIV_OFS  = 2;

  // Index 15 is the leftmost entry of the concatenation.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E D C
    7'h03, 7'h08, 7'h10, 7'h00,   // B A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  function automatic logic [6:0] seg_lookup(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/hex7seg_decoder.sv
// -----------------------------------------------------------------------------
// hex7seg_decoder
// Combinational hex digit to active-low 7-segment (gfedcba) lookup.
// Ports:
//   i_nib  in  4  hex digit
//   o_seg  out 7  segment pattern, bit 0 = segment a, 0 = lit
// -----------------------------------------------------------------------------
module hex7seg_decoder
  import mmio_out_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  assign o_seg = seg_lookup(i_nib);

endmodule

// File: rtl/mmio_output_bank.sv
// -----------------------------------------------------------------------------
// mmio_output_bank
// Memory-mapped output register bank on the LSU peripheral bus. NUM_CH
// channel registers support byte-strobed WRITE/SET/CLR/TGL, one command slot
// loads 7-segment patterns for a 32-bit hex word into channels 0..7, and all
// register reads come back one cycle later.
//
// Optional feature macro: MMIO_OUT_BLINK_EN
//   Adds BLINK_MASK (slot NUM_CH+1) and BLINK_DIV (slot NUM_CH+2); masked
//   channels are blanked on ch_o while the blink phase is high.
//
// Ports:
//   clk         in   1              clock
//   reset_n     in   1              asynchronous active-low reset
//   addr_i      in   ADDR_W         [ADDR_W-1:4] slot, [3:2] op, [1:0] ignored
//   data_in_i   in   DATA_W         write data
//   be_i        in   DATA_W/8       byte enables
//   write_en_i  in   1              write strobe
//   read_en_i   in   1              read strobe
//   data_out_o  out  DATA_W         read data, held until next read
//   rd_valid_o  out  1              one-cycle read-data pulse
//   wr_err_o    out  1              one-cycle illegal-write pulse
//   ch_o        out  NUM_CH*DATA_W  channel outputs, ch i at [i*DATA_W +: DATA_W]
// -----------------------------------------------------------------------------
module mmio_output_bank
  import mmio_out_pkg::*;
#(
  parameter int NUM_CH = 11,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int DIV_W  = 24
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [ADDR_W-1:0]        addr_i,
  input  logic [DATA_W-1:0]        data_in_i,
  input  logic [DATA_W/8-1:0]      be_i,
  input  logic                     write_en_i,
  input  logic                     read_en_i,
  output logic [DATA_W-1:0]        data_out_o,
  output logic                     rd_valid_o,
  output logic                     wr_err_o,
  output logic [NUM_CH*DATA_W-1:0] ch_o
);

  localparam int SLOT_W = ADDR_W - 4;
  localparam int NBYTE  = DATA_W / 8;
  localparam int NHEX   = (NUM_CH < 8) ? NUM_CH : 8;
  localparam logic [SLOT_W-1:0] NCH_SLOT = SLOT_W'(NUM_CH);
  localparam logic [SLOT_W-1:0] HEX_SLOT = SLOT_W'(NUM_CH + HEX_CMD_OFS);
`ifdef MMIO_OUT_BLINK_EN
  localparam logic [SLOT_W-1:0] MASK_SLOT = SLOT_W'(NUM_CH + BLINK_MASK_OFS);
  localparam logic [SLOT_W-1:0] DIV_SLOT  = SLOT_W'(NUM_CH + BLINK_DIV_OFS);
`endif

  function automatic logic [DATA_W-1:0] byte_mask(input logic [NBYTE-1:0] be);
    logic [DATA_W-1:0] m;
    m = {DATA_W{1'b0}};
    for (int b = 0; b < NBYTE; b++) begin
      m[b*8 +: 8] = {8{be[b]}};
    end
    return m;
  endfunction

  function automatic logic [DATA_W-1:0] apply_op(input op_e op,
                                                 input logic [DATA_W-1:0] r,
                                                 input logic [DATA_W-1:0] d,
                                                 input logic [DATA_W-1:0] bm);
    logic [DATA_W-1:0] res;
    case (op)
      OP_WR:   res = (r & ~bm) | (d & bm);
      OP_SET:  res = r | (d & bm);
      OP_CLR:  res = r & ~(d & bm);
      OP_TGL:  res = r ^ (d & bm);
      default: res = r;
    endcase
    return res;
  endfunction

  logic [SLOT_W-1:0] w_slot;
  op_e               w_op;
  logic [DATA_W-1:0] w_bm;
  logic              w_unused_addr;

  assign w_slot        = addr_i[ADDR_W-1:4];
  assign w_op          = op_e'(addr_i[3:2]);
  assign w_bm          = byte_mask(be_i);
  assign w_unused_addr = ^addr_i[1:0];

  // Hex command decoders: nibble k of the write data drives channel k.
  logic [DATA_W+31:0] w_din_pad;
  logic [6:0]         w_seg [8];
  assign w_din_pad = {32'd0, data_in_i};

  for (genvar k = 0; k < 8; k++) begin : g_hex
    hex7seg_decoder u_dec (
      .i_nib (w_din_pad[4*k +: 4]),
      .o_seg (w_seg[k])
    );
  end

  logic [DATA_W-1:0] w_hex_v [NUM_CH];
  for (genvar i = 0; i < NUM_CH; i++) begin : g_hexv
    if (i < 8) begin : g_dig
      assign w_hex_v[i] = {{(DATA_W-7){1'b0}}, w_seg[i]};
    end else begin : g_none
      assign w_hex_v[i] = {DATA_W{1'b0}};
    end
  end

  logic w_wr_chan, w_wr_hex, w_wr_mask, w_wr_div, w_wr_err;

  // Write decode: classify the access; anything not accepted is an error.
  always_comb begin
    w_wr_chan = 1'b0;
    w_wr_hex  = 1'b0;
    w_wr_mask = 1'b0;
    w_wr_div  = 1'b0;
    w_wr_err  = 1'b0;
    if (write_en_i) begin
      if (w_slot < NCH_SLOT) begin
        w_wr_chan = 1'b1;
      end else if (w_slot == HEX_SLOT) begin
        if (w_op == OP_WR) w_wr_hex = 1'b1;
        else               w_wr_err = 1'b1;
      end
`ifdef MMIO_OUT_BLINK_EN
      else if (w_slot == MASK_SLOT) begin
        if (w_op == OP_WR) w_wr_mask = 1'b1;
        else               w_wr_err  = 1'b1;
      end else if (w_slot == DIV_SLOT) begin
        if (w_op == OP_WR) w_wr_div = 1'b1;
        else               w_wr_err = 1'b1;
      end
`endif
      else begin
        w_wr_err = 1'b1;
      end
    end else begin
      w_wr_err = 1'b0;
    end
  end

  logic [DATA_W-1:0] r_ch     [NUM_CH];
  logic [DATA_W-1:0] w_ch_nxt [NUM_CH];
  logic [NUM_CH-1:0] w_blank_nxt;
  logic [NUM_CH*DATA_W-1:0] r_ch_out;

  // Next channel values from a channel-slot op or the hex command.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_ch_nxt[i] = r_ch[i];
      if (w_wr_chan && (w_slot == SLOT_W'(i))) begin
        w_ch_nxt[i] = apply_op(w_op, r_ch[i], data_in_i, w_bm);
      end else if (w_wr_hex && (i < NHEX)) begin
        w_ch_nxt[i] = w_hex_v[i];
      end else begin
        w_ch_nxt[i] = r_ch[i];
      end
    end
  end

`ifdef MMIO_OUT_BLINK_EN
  logic [NUM_CH-1:0] r_mask, w_mask_nxt;
  logic [DIV_W-1:0]  r_div, w_div_nxt, r_cnt, w_cnt_nxt;
  logic              r_phase, w_phase_nxt;

  // Blink registers and free-running divider; a BLINK_DIV write restarts it.
  always_comb begin
    w_mask_nxt  = r_mask;
    w_div_nxt   = r_div;
    w_cnt_nxt   = r_cnt;
    w_phase_nxt = r_phase;
    if (w_wr_mask) begin
      w_mask_nxt = (r_mask & ~w_bm[NUM_CH-1:0]) | (data_in_i[NUM_CH-1:0] & w_bm[NUM_CH-1:0]);
    end else begin
      w_mask_nxt = r_mask;
    end
    if (w_wr_div) begin
      w_div_nxt   = (r_div & ~w_bm[DIV_W-1:0]) | (data_in_i[DIV_W-1:0] & w_bm[DIV_W-1:0]);
      w_cnt_nxt   = {DIV_W{1'b0}};
      w_phase_nxt = 1'b0;
    end else if (r_div == {DIV_W{1'b0}}) begin
      w_cnt_nxt   = {DIV_W{1'b0}};
      w_phase_nxt = 1'b0;
    end else if (r_cnt == r_div) begin
      w_cnt_nxt   = {DIV_W{1'b0}};
      w_phase_nxt = ~r_phase;
    end else begin
      w_cnt_nxt   = r_cnt + DIV_W'(1);
    end
  end

  assign w_blank_nxt = {NUM_CH{w_phase_nxt}} & w_mask_nxt;

  // Blink state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask  <= {NUM_CH{1'b0}};
      r_div   <= {DIV_W{1'b0}};
      r_cnt   <= {DIV_W{1'b0}};
      r_phase <= 1'b0;
    end else begin
      r_mask  <= w_mask_nxt;
      r_div   <= w_div_nxt;
      r_cnt   <= w_cnt_nxt;
      r_phase <= w_phase_nxt;
    end
  end
`else
  logic [DIV_W-1:0] w_unused_div;
  assign w_unused_div = {DIV_W{1'b0}};
  assign w_blank_nxt  = {NUM_CH{1'b0}};
`endif

  // Channel registers; ch_o is registered from the same next values so a
  // write shows on the pins one cycle after its edge, blanking included.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_ch[i] <= {DATA_W{1'b0}};
      end
      r_ch_out <= {(NUM_CH*DATA_W){1'b0}};
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_ch[i] <= w_ch_nxt[i];
        r_ch_out[i*DATA_W +: DATA_W] <= w_blank_nxt[i] ? {DATA_W{1'b0}} : w_ch_nxt[i];
      end
    end
  end

  logic [DATA_W-1:0] w_rd_data;

  // Read mux: register contents only; HEX_CMD and unmapped slots read 0.
  always_comb begin
    w_rd_data = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      w_rd_data = w_rd_data | ((w_slot == SLOT_W'(i)) ? r_ch[i] : {DATA_W{1'b0}});
    end
`ifdef MMIO_OUT_BLINK_EN
    w_rd_data = w_rd_data | ((w_slot == MASK_SLOT) ? DATA_W'(r_mask) : {DATA_W{1'b0}});
    w_rd_data = w_rd_data | ((w_slot == DIV_SLOT)  ? DATA_W'(r_div)  : {DATA_W{1'b0}});
`endif
  end

  logic [DATA_W-1:0] r_data_out;
  logic              r_rd_valid;
  logic              r_wr_err;

  // Read-data, read-valid and write-error output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data_out <= {DATA_W{1'b0}};
      r_rd_valid <= 1'b0;
      r_wr_err   <= 1'b0;
    end else begin
      r_rd_valid <= read_en_i;
      r_wr_err   <= w_wr_err;
      if (read_en_i) r_data_out <= w_rd_data;
      else           r_data_out <= r_data_out;
    end
  end

  assign data_out_o = r_data_out;
  assign rd_valid_o = r_rd_valid;
  assign wr_err_o   = r_wr_err;
  assign ch_o       = r_ch_out;

endmodule

// File: tb/tb_mmio_output_bank.sv
module tb_mmio_output_bank;

  localparam int NUM_CH = 11;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
  localparam int DIV_W  = 24;

  logic                     clk;
  logic                     reset_n;
  logic [ADDR_W-1:0]        addr_i;
  logic [DATA_W-1:0]        data_in_i;
  logic [DATA_W/8-1:0]      be_i;
  logic                     write_en_i;
  logic                     read_en_i;
  logic [DATA_W-1:0]        data_out_o;
  logic                     rd_valid_o;
  logic                     wr_err_o;
  logic [NUM_CH*DATA_W-1:0] ch_o;

  int total = 0;
  int bad   = 0;
  logic [31:0] sb [$];
  logic [31:0] m_ch [NUM_CH];
  logic [31:0] exp_v;

  localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                     7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  mmio_output_bank #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DIV_W  (DIV_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .addr_i     (addr_i),
    .data_in_i  (data_in_i),
    .be_i       (be_i),
    .write_en_i (write_en_i),
    .read_en_i  (read_en_i),
    .data_out_o (data_out_o),
    .rd_valid_o (rd_valid_o),
    .wr_err_o   (wr_err_o),
    .ch_o       (ch_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_op(input logic [1:0] op, input logic [31:0] r,
                                           input logic [31:0] d, input logic [3:0] be);
    logic [31:0] bm;
    bm = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    case (op)
      2'b00:   return (r & ~bm) | (d & bm);
      2'b01:   return r | (d & bm);
      2'b10:   return r & ~(d & bm);
      default: return r ^ (d & bm);
    endcase
  endfunction

  // Drive one write for one cycle and update the reference model.
  task automatic wr(input int slot, input logic [1:0] op, input logic [31:0] d, input logic [3:0] be);
    addr_i     = {slot[3:0], op, 2'b00};
    data_in_i  = d;
    be_i       = be;
    write_en_i = 1'b1;
    if (slot < NUM_CH) begin
      m_ch[slot] = model_op(op, m_ch[slot], d, be);
    end else if (slot == NUM_CH && op == 2'b00) begin
      for (int k = 0; k < 8 && k < NUM_CH; k++) m_ch[k] = {25'd0, SEG[d[4*k +: 4]]};
    end
    tick();
    write_en_i = 1'b0;
  endtask

  // Issue a read for one cycle; the expected value goes to the scoreboard.
  task automatic rd(input int slot, input logic [31:0] expv);
    addr_i    = {slot[3:0], 2'b00, 2'b00};
    read_en_i = 1'b1;
    sb.push_back(expv);
    tick();
    read_en_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; write_en_i = 1'b0; read_en_i = 1'b0;
    addr_i = 8'd0; data_in_i = 32'd0; be_i = 4'd0;
    for (int i = 0; i < NUM_CH; i++) m_ch[i] = 32'd0;
    tick(); tick();
    total++;
    if (ch_o !== {(NUM_CH*DATA_W){1'b0}}) begin bad++; $display("FAIL reset_ch: got %h want 0", ch_o); end
    total++;
    if (rd_valid_o !== 1'b0 || wr_err_o !== 1'b0 || data_out_o !== 32'd0) begin
      bad++; $display("FAIL reset_out: rv=%b err=%b do=%h want 0/0/0", rd_valid_o, wr_err_o, data_out_o);
    end
    reset_n = 1'b1;
    tick();
    for (int s = 0; s < NUM_CH; s++) begin
      rd(s, 32'd0);
      total++;
      if (rd_valid_o !== 1'b1 || sb.size() == 0) begin
        bad++; $display("FAIL reset_read_valid slot %0d: rv=%b want 1", s, rd_valid_o);
      end else begin
        exp_v = sb.pop_front();
        if (data_out_o !== exp_v) begin bad++; $display("FAIL reset_read slot %0d: got %h want %h", s, data_out_o, exp_v); end
      end
    end
    tick();
    total++;
    if (rd_valid_o !== 1'b0) begin bad++; $display("FAIL rd_valid_pulse: got %b want 0", rd_valid_o); end
  endtask

  task automatic test_write();
    wr(2, 2'b00, 32'hFFFFFFFF, 4'hF);
    wr(2, 2'b00, 32'h12345678, 4'b0101);
    total++;
    if (ch_o[2*32 +: 32] !== 32'hFF34FF78) begin bad++; $display("FAIL write_bytes: got %h want ff34ff78", ch_o[2*32 +: 32]); end
    rd(2, 32'hFF34FF78);
    total++;
    if (rd_valid_o !== 1'b1 || sb.size() == 0) begin bad++; $display("FAIL write_read_valid: rv=%b want 1", rd_valid_o); end
    else begin
      exp_v = sb.pop_front();
      if (data_out_o !== exp_v) begin bad++; $display("FAIL write_read: got %h want %h", data_out_o, exp_v); end
    end
  endtask

  task automatic test_set_clr_tgl();
    wr(8, 2'b01, 32'h0F, 4'hF);
    total++;
    if (ch_o[8*32 +: 32] !== 32'h0F) begin bad++; $display("FAIL set: got %h want 0f", ch_o[8*32 +: 32]); end
    wr(8, 2'b10, 32'h03, 4'hF);
    total++;
    if (ch_o[8*32 +: 32] !== 32'h0C) begin bad++; $display("FAIL clr: got %h want 0c", ch_o[8*32 +: 32]); end
    wr(8, 2'b11, 32'h30, 4'hF);
    total++;
    if (ch_o[8*32 +: 32] !== 32'h3C) begin bad++; $display("FAIL tgl: got %h want 3c", ch_o[8*32 +: 32]); end
    wr(8, 2'b01, 32'hFFFFFFFF, 4'b0010);
    total++;
    if (ch_o[8*32 +: 32] !== 32'h0000FF3C) begin bad++; $display("FAIL set_byte: got %h want 0000ff3c", ch_o[8*32 +: 32]); end
  endtask

  task automatic test_hex();
    logic [31:0] hexp [8];
    hexp = '{32'h0E, 32'h46, 32'h03, 32'h08, 32'h30, 32'h24, 32'h79, 32'h40};
    wr(NUM_CH, 2'b00, 32'h0123ABCF, 4'h0);
    for (int k = 0; k < 8; k++) begin
      total++;
      if (ch_o[k*32 +: 32] !== hexp[k]) begin bad++; $display("FAIL hex ch%0d: got %h want %h", k, ch_o[k*32 +: 32], hexp[k]); end
    end
    total++;
    if (ch_o[8*32 +: 32] !== 32'h0000FF3C) begin bad++; $display("FAIL hex_ch8_kept: got %h want 0000ff3c", ch_o[8*32 +: 32]); end
    rd(NUM_CH, 32'd0);
    total++;
    if (rd_valid_o !== 1'b1 || sb.size() == 0) begin bad++; $display("FAIL hex_read_valid: rv=%b want 1", rd_valid_o); end
    else begin
      exp_v = sb.pop_front();
      if (data_out_o !== exp_v) begin bad++; $display("FAIL hex_read: got %h want %h", data_out_o, exp_v); end
    end
  endtask

  task automatic test_errors();
    int bad_slots [$];
    bad_slots = '{15, NUM_CH};
`ifndef MMIO_OUT_BLINK_EN
    bad_slots.push_back(NUM_CH + 1);
    bad_slots.push_back(NUM_CH + 2);
`endif
    foreach (bad_slots[j]) begin
      // slot 15 as plain write, the others with SET (illegal op on control slots)
      wr(bad_slots[j], (bad_slots[j] == 15) ? 2'b00 : 2'b01, 32'hFFFFFFFF, 4'hF);
      total++;
      if (wr_err_o !== 1'b1) begin bad++; $display("FAIL wr_err slot %0d: got %b want 1", bad_slots[j], wr_err_o); end
      tick();
      total++;
      if (wr_err_o !== 1'b0) begin bad++; $display("FAIL wr_err_pulse slot %0d: got %b want 0", bad_slots[j], wr_err_o); end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      total++;
      if (ch_o[i*32 +: 32] !== m_ch[i]) begin bad++; $display("FAIL err_no_change ch%0d: got %h want %h", i, ch_o[i*32 +: 32], m_ch[i]); end
    end
`ifndef MMIO_OUT_BLINK_EN
    rd(NUM_CH + 1, 32'd0);
    total++;
    if (rd_valid_o !== 1'b1 || sb.size() == 0) begin bad++; $display("FAIL unmapped_read_valid: rv=%b want 1", rd_valid_o); end
    else begin
      exp_v = sb.pop_front();
      if (data_out_o !== exp_v) begin bad++; $display("FAIL unmapped_read: got %h want %h", data_out_o, exp_v); end
    end
`endif
  endtask

  task automatic test_same_cycle_rw();
    wr(5, 2'b00, 32'h11111111, 4'hF);
    addr_i     = {4'd5, 2'b00, 2'b00};
    data_in_i  = 32'h22222222;
    be_i       = 4'hF;
    write_en_i = 1'b1;
    read_en_i  = 1'b1;
    sb.push_back(32'h11111111);
    m_ch[5]    = 32'h22222222;
    tick();
    write_en_i = 1'b0;
    read_en_i  = 1'b0;
    total++;
    if (rd_valid_o !== 1'b1 || sb.size() == 0) begin bad++; $display("FAIL rw_valid: rv=%b want 1", rd_valid_o); end
    else begin
      exp_v = sb.pop_front();
      if (data_out_o !== exp_v) begin bad++; $display("FAIL rw_old: got %h want %h", data_out_o, exp_v); end
    end
    total++;
    if (ch_o[5*32 +: 32] !== 32'h22222222) begin bad++; $display("FAIL rw_new: got %h want 22222222", ch_o[5*32 +: 32]); end
    tick(); tick();
    total++;
    if (data_out_o !== 32'h11111111) begin bad++; $display("FAIL data_hold: got %h want 11111111", data_out_o); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < NUM_CH; i++) begin
      wr(i, 2'(i % 4), $urandom, 4'($urandom_range(0, 15)));
    end
    for (int i = 0; i < NUM_CH; i++) begin
      rd(i, m_ch[i]);
      total++;
      if (rd_valid_o !== 1'b1 || sb.size() == 0) begin bad++; $display("FAIL b2b_valid slot %0d: rv=%b want 1", i, rd_valid_o); end
      else begin
        exp_v = sb.pop_front();
        if (data_out_o !== exp_v) begin bad++; $display("FAIL b2b_read slot %0d: got %h want %h", i, data_out_o, exp_v); end
      end
      total++;
      if (ch_o[i*32 +: 32] !== m_ch[i]) begin bad++; $display("FAIL b2b_ch ch%0d: got %h want %h", i, ch_o[i*32 +: 32], m_ch[i]); end
    end
  endtask

`ifdef MMIO_OUT_BLINK_EN
  task automatic test_blink();
    logic [31:0] e;
    wr(1, 2'b00, 32'hAA, 4'hF);
    wr(NUM_CH + 1, 2'b00, 32'h2, 4'hF);
    wr(NUM_CH + 2, 2'b00, 32'h3, 4'hF);
    for (int k = 0; k < 16; k++) begin
      if (k > 0) tick();
      e = (((k / 4) % 2) == 1) ? 32'h0 : 32'hAA;
      total++;
      if (ch_o[1*32 +: 32] !== e) begin bad++; $display("FAIL blink cyc %0d: got %h want %h", k, ch_o[1*32 +: 32], e); end
      total++;
      if (ch_o[0*32 +: 32] !== m_ch[0]) begin bad++; $display("FAIL blink_unmasked cyc %0d: got %h want %h", k, ch_o[0*32 +: 32], m_ch[0]); end
    end
    rd(NUM_CH + 2, 32'h3);
    total++;
    if (rd_valid_o !== 1'b1 || sb.size() == 0) begin bad++; $display("FAIL div_read_valid: rv=%b want 1", rd_valid_o); end
    else begin
      exp_v = sb.pop_front();
      if (data_out_o !== exp_v) begin bad++; $display("FAIL div_read: got %h want %h", data_out_o, exp_v); end
    end
    rd(1, 32'hAA);
    total++;
    if (rd_valid_o !== 1'b1 || sb.size() == 0) begin bad++; $display("FAIL blink_reg_valid: rv=%b want 1", rd_valid_o); end
    else begin
      exp_v = sb.pop_front();
      if (data_out_o !== exp_v) begin bad++; $display("FAIL blink_reg_read: got %h want %h", data_out_o, exp_v); end
    end
    wr(NUM_CH + 2, 2'b00, 32'h0, 4'hF);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      total++;
      if (ch_o[1*32 +: 32] !== 32'hAA) begin bad++; $display("FAIL blink_off cyc %0d: got %h want aa", k, ch_o[1*32 +: 32]); end
    end
    wr(NUM_CH + 1, 2'b00, 32'h0, 4'hF);
  endtask
`endif

  task automatic test_reset_mid();
    wr(3, 2'b00, 32'hCAFEF00D, 4'hF);
    addr_i     = {4'd0, 2'b00, 2'b00};
    data_in_i  = 32'hFFFFFFFF;
    be_i       = 4'hF;
    write_en_i = 1'b1;
    read_en_i  = 1'b1;
    reset_n    = 1'b0;
    for (int i = 0; i < NUM_CH; i++) m_ch[i] = 32'd0;
    tick();
    total++;
    if (ch_o !== {(NUM_CH*DATA_W){1'b0}} || rd_valid_o !== 1'b0 || data_out_o !== 32'd0) begin
      bad++; $display("FAIL reset_mid: ch=%h rv=%b do=%h want all 0", ch_o, rd_valid_o, data_out_o);
    end
    write_en_i = 1'b0;
    read_en_i  = 1'b0;
    reset_n    = 1'b1;
    tick();
    rd(3, 32'd0);
    total++;
    if (rd_valid_o !== 1'b1 || sb.size() == 0) begin bad++; $display("FAIL reset_mid_valid: rv=%b want 1", rd_valid_o); end
    else begin
      exp_v = sb.pop_front();
      if (data_out_o !== exp_v) begin bad++; $display("FAIL reset_mid_read: got %h want %h", data_out_o, exp_v); end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_set_clr_tgl();
    test_hex();
    test_errors();
    test_same_cycle_rw();
    test_back_to_back();
`ifdef MMIO_OUT_BLINK_EN
    test_blink();
`endif
    test_reset_mid();
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
